// File: rtl/burst_rr_scheduler_pkg.sv
// Shared types and defaults for the burst round-robin scheduler.
package sched_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } sched_state_e;

    localparam int unsigned DEF_NUM_REQ  = 4;
    localparam int unsigned DEF_LEN_W    = 4;
    localparam int unsigned DEF_WDOG_CYC = 16;

    // Index width for n entries, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/burst_rr_scheduler_if.sv
// Requester/resource-side bundle of the burst round-robin scheduler.
interface burst_rr_scheduler_if #(
    parameter int unsigned NUM_REQ = sched_pkg::DEF_NUM_REQ,
    parameter int unsigned LEN_W   = sched_pkg::DEF_LEN_W
);
    localparam int unsigned IDX_W = sched_pkg::idx_w(NUM_REQ);

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*LEN_W-1:0] req_len;
    logic                     beat_done;
    logic [NUM_REQ-1:0]       grant;
    logic [IDX_W-1:0]         owner;
    logic                     busy;
    logic                     last_beat;
    logic                     wdog_err;

    // Requesters and the shared resource drive requests and beat completions.
    modport master (
        output req, req_len, beat_done,
        input  grant, owner, busy, last_beat, wdog_err
    );

    // The scheduler consumes requests and drives the grant bookkeeping.
    modport slave (
        input  req, req_len, beat_done,
        output grant, owner, busy, last_beat, wdog_err
    );

endinterface

// File: rtl/burst_rr_scheduler_rr_pick.sv
// Combinational cyclic priority picker: first set request at or after ptr.
module rr_pick
    import sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]          i_req,
    input  logic [idx_w(NUM_REQ)-1:0]   i_ptr,
    output logic [NUM_REQ-1:0]          o_grant,
    output logic [idx_w(NUM_REQ)-1:0]   o_idx,
    output logic                        o_valid
);

    localparam int unsigned IDX_W = idx_w(NUM_REQ);

    // Walk upward from ptr with an explicit wrap so any NUM_REQ works.
    always_comb begin
        int unsigned w_k;
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_k     = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_k = 32'(i_ptr) + i;
            if (w_k >= NUM_REQ) begin
                w_k = w_k - NUM_REQ;
            end
            if (!o_valid && i_req[IDX_W'(w_k)]) begin
                o_valid               = 1'b1;
                o_idx                 = IDX_W'(w_k);
                o_grant[IDX_W'(w_k)]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/burst_rr_scheduler.sv
// Round-robin scheduler granting one requester a whole multi-beat burst.
// Optional watchdog abort is built when SCHED_WDOG_EN is defined.
module burst_rr_scheduler
    import sched_pkg::*;
#(
    parameter int unsigned NUM_REQ  = DEF_NUM_REQ,
    parameter int unsigned LEN_W    = DEF_LEN_W,
    parameter int unsigned WDOG_CYC = DEF_WDOG_CYC
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    burst_rr_scheduler_if.slave  io_sched
);

    localparam int unsigned IDX_W = idx_w(NUM_REQ);

    // Reject configurations the picker and watchdog cannot support.
    if (NUM_REQ < 2 || WDOG_CYC < 2) begin : g_bad_cfg
        $error("burst_rr_scheduler: NUM_REQ and WDOG_CYC must be at least 2");
    end

    sched_state_e       r_state, w_state_nxt;
    logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
    logic [IDX_W-1:0]   r_owner, w_owner_nxt;
    logic [IDX_W-1:0]   r_ptr, w_ptr_nxt;
    logic [LEN_W-1:0]   r_beat_cnt, w_beat_cnt_nxt;
    logic               r_busy;
    logic               r_last_beat, w_last_beat_nxt;
    logic               w_load;
    logic               w_burst_end;
    logic               w_abort;

    logic [NUM_REQ-1:0] w_pick_grant;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_valid;
    logic [LEN_W-1:0]   w_pick_len;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .i_req   (io_sched.req),
        .i_ptr   (r_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    // Burst length of the current pick, sampled only when the grant loads.
    always_comb begin
        w_pick_len = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_pick_idx == IDX_W'(i)) begin
                w_pick_len = io_sched.req_len[i*LEN_W +: LEN_W];
            end
        end
    end

    // Next state: beat counting, burst end and same-cycle re-arbitration.
    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_owner_nxt    = r_owner;
        w_ptr_nxt      = r_ptr;
        w_beat_cnt_nxt = r_beat_cnt;
        w_load         = 1'b0;
        w_burst_end    = 1'b0;

        case (r_state)
            IDLE: begin
                w_load = w_pick_valid;
            end
            BURST: begin
                if (io_sched.beat_done) begin
                    if (r_beat_cnt != '0) begin
                        w_beat_cnt_nxt = r_beat_cnt - LEN_W'(1);
                    end else begin
                        w_burst_end = 1'b1;
                    end
                end else if (w_abort) begin
                    w_burst_end = 1'b1;
                end
                if (w_burst_end) begin
                    if (w_pick_valid) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt    = IDLE;
                        w_grant_nxt    = '0;
                        w_beat_cnt_nxt = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase

        if (w_load) begin
            w_state_nxt    = BURST;
            w_grant_nxt    = w_pick_grant;
            w_owner_nxt    = w_pick_idx;
            w_ptr_nxt      = (w_pick_idx == IDX_W'(NUM_REQ - 1)) ? '0
                                                                 : w_pick_idx + IDX_W'(1);
            w_beat_cnt_nxt = w_pick_len;
        end

        w_last_beat_nxt = (w_state_nxt == BURST) && (w_beat_cnt_nxt == '0);
    end

    // State and grant bookkeeping registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_owner     <= '0;
            r_ptr       <= '0;
            r_beat_cnt  <= '0;
            r_busy      <= 1'b0;
            r_last_beat <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_owner     <= w_owner_nxt;
            r_ptr       <= w_ptr_nxt;
            r_beat_cnt  <= w_beat_cnt_nxt;
            r_busy      <= (w_state_nxt == BURST);
            r_last_beat <= w_last_beat_nxt;
        end
    end

`ifdef SCHED_WDOG_EN
    localparam int unsigned WDOG_W = idx_w(WDOG_CYC);

    logic [WDOG_W-1:0] r_wdog_cnt, w_wdog_cnt_nxt;
    logic              r_wdog_err;

    // Stall limit reached with no beat this cycle; a late beat still wins.
    assign w_abort = (r_state == BURST) && !io_sched.beat_done &&
                     (r_wdog_cnt == WDOG_W'(WDOG_CYC - 1));

    // Stall counter: cleared by a new grant or a beat, counts other burst cycles.
    always_comb begin
        w_wdog_cnt_nxt = '0;
        if (!w_load && (r_state == BURST) && !io_sched.beat_done) begin
            w_wdog_cnt_nxt = r_wdog_cnt + WDOG_W'(1);
        end
    end

    // Watchdog counter and one-cycle abort pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wdog_cnt <= '0;
            r_wdog_err <= 1'b0;
        end else begin
            r_wdog_cnt <= w_wdog_cnt_nxt;
            r_wdog_err <= w_abort;
        end
    end

    assign io_sched.wdog_err = r_wdog_err;
`else
    assign w_abort           = 1'b0;
    assign io_sched.wdog_err = 1'b0;
`endif

    assign io_sched.grant     = r_grant;
    assign io_sched.owner     = r_owner;
    assign io_sched.busy      = r_busy;
    assign io_sched.last_beat = r_last_beat;

endmodule
